// File: rtl/tau_pkg.sv
// Shared types for the register-transfer sequencer: FSM state encoding and the
// default bus width.
package tau_pkg;

  localparam int WORD_SIZE_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } xfer_state_t;

endpackage

// File: rtl/bus_mux_n.sv
// NUM_REGS:1 word multiplexer onto the shared data bus. Output is forced to zero
// when inactive so idle/reset cycles never drive register data onto the bus.
module bus_mux_n #(
  parameter  int WORD_SIZE = 8,
  parameter  int NUM_REGS  = 4,
  localparam int SEL_W     = $clog2(NUM_REGS)
) (
  input  logic [NUM_REGS*WORD_SIZE-1:0] i_data,
  input  logic [SEL_W-1:0]              i_sel,
  input  logic                          i_active,
  output logic [WORD_SIZE-1:0]          o_data
);

  // Only the selected slice reaches the output, so unknowns on other
  // registers can never leak onto the bus.
  always_comb begin
    o_data = '0;
    if (i_active) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i_sel == SEL_W'(i)) o_data = i_data[i*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

endmodule

// File: rtl/bus_transfer_sequencer.sv
// Sequences a register-to-register move over the shared bus:
// IDLE -> READ -> WRITE -> DONE, with illegal requests rejected in IDLE.
module bus_transfer_sequencer
  import tau_pkg::*;
#(
  parameter  int WORD_SIZE = WORD_SIZE_DEF,
  parameter  int NUM_REGS  = 4,
  localparam int SEL_W     = $clog2(NUM_REGS)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [SEL_W-1:0]              src_sel,
  input  logic [SEL_W-1:0]              dst_sel,
  input  logic [NUM_REGS*WORD_SIZE-1:0] reg_out,
  output logic [WORD_SIZE-1:0]          bus_value,
  output logic [NUM_REGS-1:0]           reg_enable,
  output logic [NUM_REGS-1:0]           reg_read,
  output logic [NUM_REGS-1:0]           reg_write,
  output logic                          done,
  output logic                          err
);

  xfer_state_t      r_state;
  logic [SEL_W-1:0] r_src;
  logic [SEL_W-1:0] r_dst;
  logic             r_done;
  logic             r_err;

  logic             w_legal;
  logic             w_active;
  logic             w_is_write;

  assign w_legal = (src_sel != dst_sel) &&
                   (int'(src_sel) < NUM_REGS) &&
                   (int'(dst_sel) < NUM_REGS);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            if (w_legal) begin
              r_src   <= src_sel;
              r_dst   <= dst_sel;
              r_state <= READ;
            end else begin
              r_err   <= 1'b1;
            end
          end
        end
        READ:  r_state <= WRITE;
        WRITE: begin
          r_state <= DONE;
          r_done  <= 1'b1;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == IDLE);
  assign done      = r_done;
  assign err       = r_err;

  // Reset gates the strobes combinationally so a reset landing in WRITE can
  // never let the destination capture the bus.
  assign w_active   = !reset && ((r_state == READ) || (r_state == WRITE));
  assign w_is_write = (r_state == WRITE);

  always_comb begin
    reg_enable = '0;
    reg_read   = '0;
    reg_write  = '0;
    if (w_active) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (r_src == SEL_W'(i)) begin
          reg_enable[i] = 1'b1;
          reg_read[i]   = 1'b1;
        end
        if (w_is_write && (r_dst == SEL_W'(i))) begin
          reg_enable[i] = 1'b1;
          reg_write[i]  = 1'b1;
        end
      end
    end
  end

  bus_mux_n #(
    .WORD_SIZE (WORD_SIZE),
    .NUM_REGS  (NUM_REGS)
  ) u_bus_mux (
    .i_data   (reg_out),
    .i_sel    (r_src),
    .i_active (w_active),
    .o_data   (bus_value)
  );

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Bench: four modelled registers on the bus, a cycle-scheduled expectation
// model, a per-cycle compare process and directed scenarios.
module tb_bus_transfer_sequencer;

  localparam int W = 8;
  localparam int N = 4;
  localparam int K_IDLE  = 0;
  localparam int K_READ  = 1;
  localparam int K_WRITE = 2;
  localparam int K_DONE  = 3;
  localparam int K_ERR   = 4;
  localparam int MAXC    = 512;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           req_valid = 1'b0;
  logic [1:0]     src_sel = '0;
  logic [1:0]     dst_sel = '0;
  logic [N*W-1:0] reg_out;
  logic [W-1:0]   bus_value;
  logic [N-1:0]   reg_enable, reg_read, reg_write;
  logic           req_ready, done, err;

  logic           b_valid = 1'b0;
  logic [1:0]     b_src = '0;
  logic [1:0]     b_dst = '0;
  logic [3*W-1:0] b_reg_out = 24'hA5B6C7;
  logic [W-1:0]   b_bus;
  logic [2:0]     b_enable, b_read, b_write;
  logic           b_ready, b_done, b_err;

  bus_transfer_sequencer #(.WORD_SIZE(W), .NUM_REGS(N)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .src_sel(src_sel), .dst_sel(dst_sel), .reg_out(reg_out), .bus_value(bus_value),
    .reg_enable(reg_enable), .reg_read(reg_read), .reg_write(reg_write),
    .done(done), .err(err)
  );

  bus_transfer_sequencer #(.WORD_SIZE(W), .NUM_REGS(3)) dut3 (
    .clock(clock), .reset(reset), .req_valid(b_valid), .req_ready(b_ready),
    .src_sel(b_src), .dst_sel(b_dst), .reg_out(b_reg_out), .bus_value(b_bus),
    .reg_enable(b_enable), .reg_read(b_read), .reg_write(b_write),
    .done(b_done), .err(b_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Register bank model
  logic [W-1:0] regs [N];
  logic         reg_x [N];
  logic         pre_en = 1'b0;
  int           pre_idx = 0;
  logic [W-1:0] pre_val = '0;
  logic         pre_x = 1'b0;
  logic [N-1:0] cap_wr = '0;
  logic [W-1:0] cap_bus = '0;
  logic         cap_x = 1'b0;

  always_comb begin
    reg_out = '0;
    for (int i = 0; i < N; i++) reg_out[i*W +: W] = reg_x[i] ? 8'hxx : regs[i];
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      regs[i]  = '0;
      reg_x[i] = 1'b0;
    end
    forever begin
      @(posedge clock);
      if (pre_en) begin
        regs[pre_idx]  = pre_val;
        reg_x[pre_idx] = pre_x;
      end
      for (int i = 0; i < N; i++) begin
        if (cap_wr[i]) begin
          regs[i]  = cap_bus;
          reg_x[i] = cap_x;
        end
      end
    end
  end

  // Expectation model: an accepted request schedules READ/WRITE/DONE into the
  // next three cycles; a rejected one schedules an error cycle.
  int cyc = 0;
  int exp_kind [MAXC];
  int exp_src  [MAXC];
  int exp_dst  [MAXC];

  initial begin
    for (int i = 0; i < MAXC; i++) begin
      exp_kind[i] = K_IDLE;
      exp_src[i]  = 0;
      exp_dst[i]  = 0;
    end
    forever begin
      @(posedge clock);
      if (cyc < MAXC - 4) begin
        if (reset) begin
          for (int k = 1; k <= 3; k++) exp_kind[cyc+k] = K_IDLE;
        end else if ((exp_kind[cyc] == K_IDLE || exp_kind[cyc] == K_ERR) && req_valid) begin
          if (src_sel != dst_sel && int'(src_sel) < N && int'(dst_sel) < N) begin
            for (int k = 1; k <= 3; k++) begin
              exp_src[cyc+k] = int'(src_sel);
              exp_dst[cyc+k] = int'(dst_sel);
            end
            exp_kind[cyc+1] = K_READ;
            exp_kind[cyc+2] = K_WRITE;
            exp_kind[cyc+3] = K_DONE;
          end else begin
            exp_kind[cyc+1] = K_ERR;
          end
        end
      end
      cyc++;
    end
  end

  logic chk_en = 1'b0;

  initial begin
    int k, s, d;
    logic [N-1:0] e_en, e_rd, e_wr;
    logic [W-1:0] e_bus;
    logic         dc;
    forever begin
      @(negedge clock);
      k = exp_kind[cyc]; s = exp_src[cyc]; d = exp_dst[cyc];
      e_en = '0; e_rd = '0; e_wr = '0; e_bus = '0; dc = 1'b0;
      if (!reset && (k == K_READ || k == K_WRITE)) begin
        e_en[s] = 1'b1; e_rd[s] = 1'b1;
        e_bus = regs[s]; dc = reg_x[s];
        if (k == K_WRITE) begin
          e_en[d] = 1'b1; e_wr[d] = 1'b1;
        end
      end
      if (chk_en) begin
        chk("cyc_enable", 32'(reg_enable), 32'(e_en));
        chk("cyc_read",   32'(reg_read),   32'(e_rd));
        chk("cyc_write",  32'(reg_write),  32'(e_wr));
        if (!dc) chk("cyc_bus", 32'(bus_value), 32'(e_bus));
        chk("cyc_ready", 32'(req_ready), 32'(k == K_IDLE || k == K_ERR));
        chk("cyc_done",  32'(done),      32'(k == K_DONE));
        chk("cyc_err",   32'(err),       32'(k == K_ERR));
      end
      cap_wr  = reg_write & reg_enable;
      cap_bus = bus_value;
      cap_x   = dc;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic preload(input int idx, input logic [W-1:0] val, input logic x);
    pre_en = 1'b1; pre_idx = idx; pre_val = val; pre_x = x;
    step(1);
    pre_en = 1'b0; pre_x = 1'b0;
  endtask

  initial begin
    // Reset state
    step(2);
    chk("rst_enable", 32'(reg_enable), 32'h0);
    chk("rst_read",   32'(reg_read),   32'h0);
    chk("rst_write",  32'(reg_write),  32'h0);
    chk("rst_bus",    32'(bus_value),  32'h0);
    chk("rst_ready",  32'(req_ready),  32'h1);
    chk("rst_done",   32'(done),       32'h0);
    chk("rst_err",    32'(err),        32'h0);
    chk("rst3_strobes", 32'({b_enable, b_read, b_write}), 32'h0);
    chk("rst3_bus",   32'(b_bus),      32'h0);
    chk("rst3_flags", 32'({b_ready, b_done, b_err}), 32'b100);
    chk_en = 1'b1;
    reset  = 1'b0;

    // Normal transfer reg1 -> reg2
    preload(1, 8'hDE, 1'b0);
    src_sel = 2'd1; dst_sel = 2'd2; req_valid = 1'b1;
    step(1);
    req_valid = 1'b0;
    chk("nrm_rd_enable", 32'(reg_enable), 32'b0010);
    chk("nrm_rd_read",   32'(reg_read),   32'b0010);
    step(1);
    chk("nrm_wr_enable", 32'(reg_enable), 32'b0110);
    chk("nrm_wr_write",  32'(reg_write),  32'b0100);
    chk("nrm_wr_bus",    32'(bus_value),  32'hDE);
    step(1);
    chk("nrm_done",      32'(done),       32'h1);
    chk("nrm_done_bus",  32'(bus_value),  32'h0);
    step(1);
    chk("nrm_ready",     32'(req_ready),  32'h1);
    chk("nrm_reg2",      32'(regs[2]),    32'hDE);
    chk("nrm_reg1",      32'(regs[1]),    32'hDE);

    // Illegal requests on both instances
    src_sel = 2'd3; dst_sel = 2'd3; req_valid = 1'b1;
    b_src = 2'd0; b_dst = 2'd3; b_valid = 1'b1;
    step(1);
    req_valid = 1'b0; b_valid = 1'b0;
    chk("ill_err",     32'(err),        32'h1);
    chk("ill_enable",  32'(reg_enable), 32'h0);
    chk("ill_ready",   32'(req_ready),  32'h1);
    chk("ill3_err",    32'(b_err),      32'h1);
    chk("ill3_enable", 32'(b_enable),   32'h0);
    chk("ill3_ready",  32'(b_ready),    32'h1);
    step(1);
    chk("ill_err_clr",  32'(err),   32'h0);
    chk("ill3_err_clr", 32'(b_err), 32'h0);

    // Back-to-back with busy-time input changes
    preload(0, 8'h3C, 1'b0);
    src_sel = 2'd0; dst_sel = 2'd1; req_valid = 1'b1;
    step(1);
    src_sel = 2'd2; dst_sel = 2'd2;
    step(1);
    src_sel = 2'd1; dst_sel = 2'd3;
    step(2);
    chk("b2b_ready_at4", 32'(req_ready), 32'h1);
    step(1);
    req_valid = 1'b0;
    chk("b2b_rd_read",  32'(reg_read),  32'b0010);
    chk("b2b_rd_write", 32'(reg_write), 32'b0000);
    step(1);
    chk("b2b_wr_write", 32'(reg_write), 32'b1000);
    chk("b2b_wr_bus",   32'(bus_value), 32'h3C);
    step(2);
    chk("b2b_reg1", 32'(regs[1]), 32'h3C);
    chk("b2b_reg3", 32'(regs[3]), 32'h3C);

    // Reset in the WRITE cycle
    preload(0, 8'h5A, 1'b0);
    preload(2, 8'h11, 1'b0);
    src_sel = 2'd0; dst_sel = 2'd2; req_valid = 1'b1;
    step(1);
    req_valid = 1'b0;
    step(1);
    reset = 1'b1;
    #1;
    chk("rstw_write", 32'(reg_write),  32'h0);
    chk("rstw_bus",   32'(bus_value),  32'h0);
    chk("rstw_enable", 32'(reg_enable), 32'h0);
    step(1);
    reset = 1'b0;
    chk("rstw_done",  32'(done),      32'h0);
    chk("rstw_ready", 32'(req_ready), 32'h1);
    step(3);
    chk("rstw_reg2",  32'(regs[2]),   32'h11);

    // Unknown source register value
    preload(0, 8'h00, 1'b1);
    src_sel = 2'd0; dst_sel = 2'd1; req_valid = 1'b1;
    chk("x_idle_bus", 32'(bus_value), 32'h0);
    step(1);
    req_valid = 1'b0;
    chk("x_rd_enable", 32'(reg_enable), 32'b0001);
    step(1);
    chk("x_wr_write",  32'(reg_write),  32'b0010);
    step(1);
    chk("x_done_bus",  32'(bus_value),  32'h0);
    chk("x_done",      32'(done),       32'h1);
    step(1);
    chk("x_idle_bus2", 32'(bus_value),  32'h0);
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
